// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment scan controller.
//   scan_state_t : scan FSM states
//   SEG_OFF      : all segments dark (active-low)
//   GLYPH        : hex glyph table, active-low, bit order {g,f,e,d,c,b,a}
package display_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } scan_state_t;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Entry i is the glyph for value i; 'b' and 'd' are the lowercase forms.
   localparam logic [15:0][6:0] GLYPH = {
      7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
      7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
      7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
      7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
   };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex-to-seven-segment decoder.
//   value : 4-bit digit value, 0-F
//   seg_n : active-low segments {g,f,e,d,c,b,a}
module seg7_decoder
   import display_pkg::*;
(
   input  logic [3:0] value,
   output logic [6:0] seg_n
);

   assign seg_n = GLYPH[value];

endmodule

// File: rtl/display_scan_controller.sv
// Seven-segment display scanner: lights one digit at a time for CLK_DIV clocks,
// with a BLANK_CYCLES all-dark guard between digits to suppress ghosting.
//   clk, rst     : clock, asynchronous active-low reset
//   en           : scan enable, low = display dark and scan restarts at digit 0
//   digit_data   : 4 bits per digit, dp_in / digit_mask one bit per digit
//   anode_n      : one-hot-low digit select (registered)
//   seg_n, dp_n  : active-low segments and decimal point (registered)
//   frame_done   : one-clock pulse after the last digit's lit interval
//   cur_digit    : digit index being blanked or shown
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | scan disabled, outputs dark
// BLANK | guard interval before cur_digit, all anodes off
// SHOW  | cur_digit lit from values captured on entry
module display_scan_controller
   import display_pkg::*;
#(
   parameter int NUM_DIGITS   = 8,
   parameter int CLK_DIV      = 4096,
   parameter int BLANK_CYCLES = 16
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [4*NUM_DIGITS-1:0]   digit_data,
   input  logic [NUM_DIGITS-1:0]     dp_in,
   input  logic [NUM_DIGITS-1:0]     digit_mask,
   output logic [NUM_DIGITS-1:0]     anode_n,
   output logic [6:0]                seg_n,
   output logic                      dp_n,
   output logic                      frame_done,
   output logic [2:0]                cur_digit
);

   localparam int TMAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [TW-1:0] SHOW_LOAD  = TW'(CLK_DIV - 1);
   localparam logic [TW-1:0] BLANK_LOAD = TW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

   scan_state_t             state, state_nxt;
   logic [TW-1:0]           timer, timer_nxt;
   logic [2:0]              digit_nxt, wrap_digit;
   logic                    last_digit, frame_nxt, load_show;
   logic [31:0]             data_pad;
   logic [7:0]              dp_pad, mask_pad, sel_n;
   logic [3:0]              nibble;
   logic [6:0]              glyph;
   logic [NUM_DIGITS-1:0]   anode_nxt;
   logic [6:0]              seg_nxt;
   logic                    dp_nxt;

   assign last_digit = (cur_digit == 3'(NUM_DIGITS - 1));
   assign wrap_digit = last_digit ? 3'd0 : cur_digit + 3'd1;

   // Timers count down to zero; the load value is length-1.
   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      digit_nxt = cur_digit;
      frame_nxt = 1'b0;
      load_show = 1'b0;
      if (!en) begin
         state_nxt = IDLE;
         timer_nxt = '0;
         digit_nxt = 3'd0;
      end else begin
         case (state)
            IDLE: begin
               digit_nxt = 3'd0;
               if (BLANK_CYCLES == 0) begin
                  state_nxt = SHOW;
                  timer_nxt = SHOW_LOAD;
                  load_show = 1'b1;
               end else begin
                  state_nxt = BLANK;
                  timer_nxt = BLANK_LOAD;
               end
            end
            BLANK: begin
               if (timer == '0) begin
                  state_nxt = SHOW;
                  timer_nxt = SHOW_LOAD;
                  load_show = 1'b1;
               end else begin
                  timer_nxt = timer - TW'(1);
               end
            end
            SHOW: begin
               if (timer == '0) begin
                  digit_nxt = wrap_digit;
                  frame_nxt = last_digit;
                  if (BLANK_CYCLES == 0) begin
                     state_nxt = SHOW;
                     timer_nxt = SHOW_LOAD;
                     load_show = 1'b1;
                  end else begin
                     state_nxt = BLANK;
                     timer_nxt = BLANK_LOAD;
                  end
               end else begin
                  timer_nxt = timer - TW'(1);
               end
            end
            default: begin
               state_nxt = IDLE;
               timer_nxt = '0;
               digit_nxt = 3'd0;
            end
         endcase
      end
   end

   // Select the digit about to be shown (digit_nxt), so a back-to-back
   // SHOW with no guard picks up the next digit's data on the same edge.
   assign data_pad = 32'(digit_data);
   assign dp_pad   = 8'(dp_in);
   assign mask_pad = 8'(digit_mask);
   assign nibble   = data_pad[{digit_nxt, 2'b00} +: 4];
   assign sel_n    = ~(8'd1 << digit_nxt);

   seg7_decoder u_dec (
      .value (nibble),
      .seg_n (glyph)
   );

   // Outputs are captured on entry to SHOW and held; all other states are dark.
   always_comb begin
      anode_nxt = '1;
      seg_nxt   = SEG_OFF;
      dp_nxt    = 1'b1;
      if (load_show) begin
         anode_nxt = mask_pad[digit_nxt] ? sel_n[NUM_DIGITS-1:0] : '1;
         seg_nxt   = glyph;
         dp_nxt    = mask_pad[digit_nxt] ? ~dp_pad[digit_nxt] : 1'b1;
      end else if (state_nxt == SHOW) begin
         anode_nxt = anode_n;
         seg_nxt   = seg_n;
         dp_nxt    = dp_n;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         timer      <= '0;
         cur_digit  <= 3'd0;
         anode_n    <= '1;
         seg_n      <= SEG_OFF;
         dp_n       <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         timer      <= timer_nxt;
         cur_digit  <= digit_nxt;
         anode_n    <= anode_nxt;
         seg_n      <= seg_nxt;
         dp_n       <= dp_nxt;
         frame_done <= frame_nxt;
      end
   end

endmodule

// File: tb/tb_display_scan_controller.sv
module tb_display_scan_controller;

   localparam int NA = 8, CA = 4, BA = 2, PA = CA + BA, FA = NA * PA;
   localparam int NB = 3, CB = 4, BB = 0, PB = CB + BB, FB = NB * PB;

   logic clk = 1'b0, rst = 1'b0, en_a = 1'b0, en_b = 1'b0;
   logic [31:0] data_a = '0;
   logic [7:0]  dp_a = '0, mask_a = 8'hFF;
   logic [11:0] data_b = '0;
   logic [2:0]  dp_b = '0, mask_b = 3'b111;

   logic [7:0] anode_a; logic [6:0] seg_a; logic dpn_a, fd_a; logic [2:0] cur_a;
   logic [2:0] anode_b; logic [6:0] seg_b; logic dpn_b, fd_b; logic [2:0] cur_b;
   logic [19:0] got_a;
   logic [14:0] got_b;
   assign got_a = {anode_a, seg_a, dpn_a, fd_a, cur_a};
   assign got_b = {anode_b, seg_b, dpn_b, fd_b, cur_b};

   int vec = 0, err = 0;

   // Standard active-high glyphs {g,f,e,d,c,b,a}; the pins are the inverse.
   logic [6:0] seg_on [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   display_scan_controller #(.NUM_DIGITS(NA), .CLK_DIV(CA), .BLANK_CYCLES(BA)) dut_a (
      .clk(clk), .rst(rst), .en(en_a), .digit_data(data_a), .dp_in(dp_a),
      .digit_mask(mask_a), .anode_n(anode_a), .seg_n(seg_a), .dp_n(dpn_a),
      .frame_done(fd_a), .cur_digit(cur_a));

   display_scan_controller #(.NUM_DIGITS(NB), .CLK_DIV(CB), .BLANK_CYCLES(BB)) dut_b (
      .clk(clk), .rst(rst), .en(en_b), .digit_data(data_b), .dp_in(dp_b),
      .digit_mask(mask_b), .anode_n(anode_b), .seg_n(seg_b), .dp_n(dpn_b),
      .frame_done(fd_b), .cur_digit(cur_b));

   always #5 clk = ~clk;

   // Reference model: c counts clocks since the enabling edge; each digit
   // period is BLANK guard clocks then SHOW lit clocks, slot = c / period.
   bit act_a = 0, act_b = 0;
   int ca = 0, cb = 0;
   logic [3:0] capv_a = '0, capv_b = '0;
   bit capm_a = 0, capp_a = 0, capm_b = 0, capp_b = 0;

   always @(posedge clk or negedge rst) begin
      int s;
      if (!rst || !en_a) begin act_a = 0; ca = 0; end
      else begin
         if (act_a) ca++; else begin act_a = 1; ca = 0; end
         if (ca % PA == BA) begin
            s = (ca / PA) % NA;
            capv_a = data_a[s*4 +: 4]; capm_a = mask_a[s]; capp_a = dp_a[s];
         end
      end
   end

   always @(posedge clk or negedge rst) begin
      int s;
      if (!rst || !en_b) begin act_b = 0; cb = 0; end
      else begin
         if (act_b) cb++; else begin act_b = 1; cb = 0; end
         if (cb % PB == BB) begin
            s = (cb / PB) % NB;
            capv_b = data_b[s*4 +: 4]; capm_b = mask_b[s]; capp_b = dp_b[s];
         end
      end
   end

   function automatic int slot_a();
      return act_a ? (ca / PA) % NA : 0;
   endfunction

   function automatic logic [19:0] exp_a();
      int s; bit lit; logic [7:0] an; logic [6:0] sg; logic dp, fd;
      s   = slot_a();
      lit = act_a && (ca % PA) >= BA;
      an  = (lit && capm_a) ? ~(8'd1 << s) : 8'hFF;
      sg  = lit ? ~seg_on[capv_a] : 7'h7F;
      dp  = (lit && capm_a) ? ~capp_a : 1'b1;
      fd  = act_a && ca > 0 && (ca % FA) == 0;
      return {an, sg, dp, fd, 3'(s)};
   endfunction

   function automatic logic [14:0] exp_b();
      int s; bit lit; logic [2:0] an; logic [6:0] sg; logic dp, fd;
      s   = act_b ? (cb / PB) % NB : 0;
      lit = act_b && (cb % PB) >= BB;
      an  = (lit && capm_b) ? ~(3'd1 << s) : 3'b111;
      sg  = lit ? ~seg_on[capv_b] : 7'h7F;
      dp  = (lit && capm_b) ? ~capp_b : 1'b1;
      fd  = act_b && cb > 0 && (cb % FB) == 0;
      return {an, sg, dp, fd, 3'(s)};
   endfunction

   task automatic restart_a();
      en_a = 1'b0;
      @(negedge clk);
      en_a = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      vec++;
      if (got_a !== {8'hFF, 7'h7F, 1'b1, 1'b0, 3'd0}) begin
         err++; $display("FAIL reset_a got %h expected %h", got_a, {8'hFF, 7'h7F, 1'b1, 1'b0, 3'd0});
      end
      vec++;
      if (got_b !== {3'b111, 7'h7F, 1'b1, 1'b0, 3'd0}) begin
         err++; $display("FAIL reset_b got %h expected %h", got_b, {3'b111, 7'h7F, 1'b1, 1'b0, 3'd0});
      end
      rst = 1'b1;
   endtask

   task automatic test_scan_order();
      data_a = 32'h76543210; mask_a = 8'hFF; dp_a = 8'($urandom);
      restart_a();
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         vec++;
         if (got_a !== exp_a()) begin
            err++; $display("FAIL scan_order cyc %0d got %h expected %h", i, got_a, exp_a());
         end
         if (act_a && slot_a() == 0 && (ca % PA) >= BA) begin
            vec++;
            if (seg_a !== 7'h40) begin
               err++; $display("FAIL digit0_glyph got %h expected 40", seg_a);
            end
         end
      end
   endtask

   task automatic test_frame_done();
      int last = -1, pulses = 0;
      data_a = $urandom; dp_a = 8'($urandom);
      restart_a();
      for (int i = 0; i < 3 * FA + 6; i++) begin
         @(negedge clk);
         vec++;
         if (got_a !== exp_a()) begin
            err++; $display("FAIL frame_run cyc %0d got %h expected %h", i, got_a, exp_a());
         end
         if (fd_a) begin
            pulses++;
            vec++;
            if (last >= 0 && i - last != FA) begin
               err++; $display("FAIL frame_spacing got %0d expected %0d", i - last, FA);
            end
            last = i;
         end
      end
      vec++;
      if (pulses != 3) begin
         err++; $display("FAIL frame_count got %0d expected 3", pulses);
      end
   endtask

   task automatic test_mask();
      data_a = $urandom; dp_a = 8'($urandom); mask_a = 8'b1010_1010;
      restart_a();
      for (int i = 0; i < 2 * FA; i++) begin
         @(negedge clk);
         vec++;
         if (got_a !== exp_a()) begin
            err++; $display("FAIL mask cyc %0d got %h expected %h", i, got_a, exp_a());
         end
         if (act_a && slot_a() % 2 == 0) begin
            vec++;
            if (anode_a !== 8'hFF) begin
               err++; $display("FAIL mask_dark slot %0d got %h expected ff", slot_a(), anode_a);
            end
         end
      end
      mask_a = 8'hFF;
   endtask

   task automatic test_capture();
      logic [3:0] old_v;
      int k;
      data_a = $urandom; dp_a = 8'($urandom);
      restart_a();
      for (k = 0; k < 200; k++) begin
         @(negedge clk);
         if (act_a && slot_a() == 3 && (ca % PA) == BA + 1) break;
      end
      vec++;
      if (k >= 200) begin
         err++; $display("FAIL capture_wait got timeout expected digit 3 SHOW");
      end
      old_v = data_a[15:12];
      data_a = $urandom;
      data_a[15:12] = old_v ^ 4'($urandom_range(1, 15));
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         vec++;
         if (seg_a !== ~seg_on[old_v]) begin
            err++; $display("FAIL capture_hold got %h expected %h", seg_a, ~seg_on[old_v]);
         end
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         vec++;
         if (got_a !== exp_a()) begin
            err++; $display("FAIL capture_next cyc %0d got %h expected %h", i, got_a, exp_a());
         end
      end
   endtask

   task automatic test_reset_mid_show();
      int k;
      data_a = $urandom; dp_a = 8'($urandom);
      restart_a();
      for (k = 0; k < 200; k++) begin
         @(negedge clk);
         if (act_a && slot_a() == 5 && (ca % PA) == BA + 1) break;
      end
      vec++;
      if (k >= 200) begin
         err++; $display("FAIL reset_wait got timeout expected digit 5 SHOW");
      end
      #2 rst = 1'b0;
      #1;
      vec++;
      if (got_a !== {8'hFF, 7'h7F, 1'b1, 1'b0, 3'd0}) begin
         err++; $display("FAIL reset_mid_show got %h expected %h", got_a, {8'hFF, 7'h7F, 1'b1, 1'b0, 3'd0});
      end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         vec++;
         if (got_a !== exp_a()) begin
            err++; $display("FAIL reset_release cyc %0d got %h expected %h", i, got_a, exp_a());
         end
      end
   endtask

   task automatic test_random();
      int drop = 0;
      restart_a();
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         vec++;
         if (got_a !== exp_a()) begin
            err++; $display("FAIL random cyc %0d got %h expected %h", i, got_a, exp_a());
         end
         if ($urandom_range(0, 7) == 0) data_a = $urandom;
         if ($urandom_range(0, 15) == 0) mask_a = 8'($urandom);
         if ($urandom_range(0, 15) == 0) dp_a = 8'($urandom);
         if (drop > 0) begin
            drop--;
            if (drop == 0) en_a = 1'b1;
         end else if ($urandom_range(0, 59) == 0) begin
            en_a = 1'b0;
            drop = $urandom_range(1, 3);
         end
      end
      en_a = 1'b1;
   endtask

   task automatic test_no_blank();
      logic [2:0] pat [3];
      int k;
      pat[0] = 3'b110; pat[1] = 3'b101; pat[2] = 3'b011;
      data_b = 12'($urandom); dp_b = 3'($urandom); mask_b = 3'b111;
      en_b = 1'b0;
      @(negedge clk);
      en_b = 1'b1;
      for (int i = 0; i < 2 * FB; i++) begin
         @(negedge clk);
         vec++;
         if (got_b !== exp_b()) begin
            err++; $display("FAIL no_blank cyc %0d got %h expected %h", i, got_b, exp_b());
         end
         vec++;
         if (anode_b !== pat[(i / CB) % NB]) begin
            err++; $display("FAIL no_blank_anode cyc %0d got %b expected %b", i, anode_b, pat[(i / CB) % NB]);
         end
      end
      // Drop enable on the last lit clock of the last digit: frame_done must not fire.
      for (k = 0; k < 50; k++) begin
         if (act_b && (cb % FB) == FB - 1) break;
         @(negedge clk);
      end
      vec++;
      if (k >= 50) begin
         err++; $display("FAIL abort_wait got timeout expected last SHOW clock");
      end
      en_b = 1'b0;
      @(negedge clk);
      vec++;
      if (got_b !== {3'b111, 7'h7F, 1'b1, 1'b0, 3'd0}) begin
         err++; $display("FAIL abort got %h expected %h", got_b, {3'b111, 7'h7F, 1'b1, 1'b0, 3'd0});
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         vec++;
         if (fd_b !== 1'b0 || anode_b !== 3'b111) begin
            err++; $display("FAIL abort_dark cyc %0d got fd=%b an=%b expected fd=0 an=111", i, fd_b, anode_b);
         end
      end
   endtask

   initial begin
      test_reset();
      test_scan_order();
      test_frame_done();
      test_mask();
      test_capture();
      test_reset_mid_show();
      test_random();
      test_no_blank();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
